sync_hold_launcher: RTL and testbench

//  Launch-side feeder for the multi-bit bus synchronizer. Runs in the source clock domain.

---
 rtl/sync_hold_launcher_if.sv | 22 ++
 rtl/sync_hold_launcher.sv | 113 +++++++++++
 tb/tb_sync_hold_launcher.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_hold_launcher_if.sv
// Handshake and launch-side bus between a word producer and sync_hold_launcher.
interface sync_hold_launcher_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_update;
    logic             busy;
    logic [7:0]       drop_cnt;

    modport master (
        output din, din_valid,
        input  din_ready, dout, dout_update, busy, drop_cnt
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dout, dout_update, busy, drop_cnt
    );
endinterface

// File: rtl/sync_hold_launcher.sv
// Launch-side feeder for a multi-bit bus synchronizer: holds each launched word stable
// for HOLD_CYCLES clocks, optionally coalescing words that arrive during the hold.
module sync_hold_launcher #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      HOLD_CYCLES = 8,
    parameter int unsigned      COALESCE    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input logic                 clk,
    input logic                 srst,
    sync_hold_launcher_if.slave bus
);
    localparam int unsigned      CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]       DROP_MAX = 8'hFF;
    localparam bit               COAL_EN  = (COALESCE != 0);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] dout_q, dout_nxt;
    logic [WIDTH-1:0] pend_q, pend_nxt;
    logic             pend_v_q, pend_v_nxt;
    logic             upd_q, upd_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [7:0]       drop_q, drop_nxt;
    logic             ready;
    logic             accept;
    logic             cand_v;
    logic [WIDTH-1:0] cand;

    // State register and launch datapath registers
    always_ff @(posedge clk) begin
        if (srst) begin
            state    <= IDLE;
            dout_q   <= RESET_VAL;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            upd_q    <= 1'b0;
            cnt_q    <= '0;
            drop_q   <= '0;
        end else begin
            state    <= state_nxt;
            dout_q   <= dout_nxt;
            pend_q   <= pend_nxt;
            pend_v_q <= pend_v_nxt;
            upd_q    <= upd_nxt;
            cnt_q    <= cnt_nxt;
            drop_q   <= drop_nxt;
        end
    end

    // Next state: launch, hold countdown, coalescing and relaunch at hold end
    always_comb begin
        state_nxt  = state;
        dout_nxt   = dout_q;
        pend_nxt   = pend_q;
        pend_v_nxt = pend_v_q;
        upd_nxt    = 1'b0;
        cnt_nxt    = cnt_q;
        drop_nxt   = drop_q;
        accept     = bus.din_valid & ready;
        // A word accepted on the last hold cycle takes precedence over the pending one
        cand_v     = accept | pend_v_q;
        cand       = accept ? bus.din : pend_q;

        case (state)
            IDLE: begin
                if (accept && (bus.din != dout_q)) begin
                    dout_nxt  = bus.din;
                    upd_nxt   = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    pend_nxt   = bus.din;
                    pend_v_nxt = 1'b1;
                    if (pend_v_q && (drop_q != DROP_MAX)) drop_nxt = drop_q + 8'd1;
                end
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else begin
                    pend_v_nxt = 1'b0;
                    if (cand_v && (cand != dout_q)) begin
                        dout_nxt = cand;
                        upd_nxt  = 1'b1;
                        cnt_nxt  = CNT_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status decode
    always_comb begin
        ready = 1'b1;
        if ((state == HOLD) && !COAL_EN) ready = 1'b0;
        bus.din_ready = ready;
        bus.busy      = (state == HOLD) | pend_v_q;
    end

    assign bus.dout        = dout_q;
    assign bus.dout_update = upd_q;
    assign bus.drop_cnt    = drop_q;
endmodule

// File: tb/tb_sync_hold_launcher.sv
// Scoreboard bench for sync_hold_launcher: one backpressuring and one coalescing instance
// share stimulus; a behavioural model predicts launches and status.
module tb_sync_hold_launcher;
    localparam int unsigned W   = 16;
    localparam int unsigned HC  = 4;
    localparam logic [15:0] RV0 = 16'h0000;
    localparam logic [15:0] RV1 = 16'hBEEF;

    typedef struct {
        bit          hold;
        int unsigned left;
        bit          pv;
        logic [15:0] pend;
        logic [15:0] dout;
        int unsigned drop;
        bit          upd;
    } model_t;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    sync_hold_launcher_if #(.WIDTH(W)) b0 ();
    sync_hold_launcher_if #(.WIDTH(W)) b1 ();

    sync_hold_launcher #(.WIDTH(W), .HOLD_CYCLES(HC), .COALESCE(0), .RESET_VAL(RV0)) u_nc (
        .clk(clk), .srst(srst), .bus(b0.slave));
    sync_hold_launcher #(.WIDTH(W), .HOLD_CYCLES(HC), .COALESCE(1), .RESET_VAL(RV1)) u_c (
        .clk(clk), .srst(srst), .bus(b1.slave));

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          chk_on   = 1'b0;
    model_t      m0, m1;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: "left" = hold clocks still owed after this one; launch when a differing word is due
    function automatic model_t step(model_t m, bit coal, logic [15:0] rv, bit rst, bit v,
                                    logic [15:0] d);
        model_t n = m;
        bit acc;
        bit have;
        logic [15:0] word;
        n.upd = 1'b0;
        if (rst) begin
            n.hold = 0; n.left = 0; n.pv = 0; n.pend = '0; n.dout = rv; n.drop = 0;
            return n;
        end
        acc = v && (!m.hold || coal);
        if (!m.hold) begin
            if (acc && d != m.dout) begin
                n.dout = d; n.upd = 1; n.hold = 1; n.left = HC - 1;
            end
            return n;
        end
        if (acc) begin
            if (m.pv) n.drop = (m.drop < 255) ? m.drop + 1 : 255;
            n.pv = 1; n.pend = d;
        end
        if (m.left > 0) begin
            n.left = m.left - 1;
            return n;
        end
        have = acc || m.pv;
        word = acc ? d : m.pend;
        n.pv = 0;
        if (have && word != m.dout) begin
            n.dout = word; n.upd = 1; n.left = HC - 1;
        end else begin
            n.hold = 0;
        end
        return n;
    endfunction

    task automatic compare_all();
        check("nc_dout",  b0.dout,        m0.dout);
        check("nc_upd",   b0.dout_update, m0.upd);
        check("nc_busy",  b0.busy,        m0.hold || m0.pv);
        check("nc_ready", b0.din_ready,   !m0.hold);
        check("nc_drop",  b0.drop_cnt,    m0.drop);
        check("c_dout",   b1.dout,        m1.dout);
        check("c_upd",    b1.dout_update, m1.upd);
        check("c_busy",   b1.busy,        m1.hold || m1.pv);
        check("c_ready",  b1.din_ready,   1);
        check("c_drop",   b1.drop_cnt,    m1.drop);
    endtask

    // One clock: check model vs DUT mid-cycle, drive, then advance the model at the edge
    task automatic cycle(bit rst, bit v, logic [15:0] d);
        @(negedge clk);
        if (chk_on) compare_all();
        srst = rst;
        b0.din = d; b0.din_valid = v;
        b1.din = d; b1.din_valid = v;
        @(posedge clk);
        m0 = step(m0, 1'b0, RV0, rst, v, d);
        m1 = step(m1, 1'b1, RV1, rst, v, d);
        if (m0.upd) q0.push_back(m0.dout);
        if (m1.upd) q1.push_back(m1.dout);
        if (rst) chk_on = 1'b1;
    endtask

    // Monitors: every presented update must match the next predicted launch
    always @(posedge clk) begin
        #1;
        if (chk_on && b0.dout_update === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++;
                $display("FAIL nc_launch: got unexpected update %0h expected none", b0.dout);
            end else check("nc_launch", b0.dout, q0.pop_front());
        end
        if (chk_on && b1.dout_update === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL c_launch: got unexpected update %0h expected none", b1.dout);
            end else check("c_launch", b1.dout, q1.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned base;
        srst = 1'b1;
        b0.din = '0; b0.din_valid = 1'b0;
        b1.din = '0; b1.din_valid = 1'b0;
        m0 = step(m0, 1'b0, RV0, 1'b1, 1'b0, '0);
        m1 = step(m1, 1'b1, RV1, 1'b1, 1'b0, '0);

        cycle(1, 0, '0);
        cycle(1, 0, '0);
        #1;
        check("rst_dout_nc", b0.dout, 16'h0000);
        check("rst_dout_c",  b1.dout, 16'hBEEF);
        check("rst_busy",    b0.busy, 0);
        check("rst_ready",   b0.din_ready, 1);

        // Single word: one update pulse, busy for HC clocks
        cycle(0, 1, 16'h1234);
        #1;
        check("t1_dout", b0.dout, 16'h1234);
        check("t1_upd",  b0.dout_update, 1);
        for (int i = 0; i < int'(HC); i++) begin
            check("t1_busy_hi", b0.busy, 1);
            cycle(0, 0, '0);
            #1;
        end
        check("t1_busy_lo", b0.busy, 0);

        // Word equal to dout in IDLE is consumed silently
        cycle(0, 1, 16'h1234);
        #1;
        check("t4_upd",  b0.dout_update, 0);
        check("t4_busy", b0.busy, 0);

        // Backpressure: second word waits for hold to end, then IDLE accept
        cycle(0, 1, 16'h000A);
        #1;
        for (int i = 0; i < int'(HC); i++) begin
            check("t2_ready_lo", b0.din_ready, 0);
            cycle(0, 1, 16'h000B);
            #1;
        end
        check("t2_ready_hi", b0.din_ready, 1);
        check("t2_held",     b0.dout, 16'h000A);
        cycle(0, 1, 16'h000B);
        #1;
        check("t2_launch_b", b0.dout, 16'h000B);

        repeat (6) cycle(0, 0, '0);

        // Coalescing: only the newest of three hold-time words launches
        base = m1.drop;
        cycle(0, 1, 16'h0040);
        cycle(0, 1, 16'h0001);
        cycle(0, 1, 16'h0002);
        cycle(0, 1, 16'h0003);
        cycle(0, 0, '0);
        #1;
        check("t3_dout", b1.dout, 16'h0003);
        check("t3_drop", b1.drop_cnt, base + 2);

        // Word on the last hold cycle displaces pending 0x5
        base = m1.drop;
        cycle(0, 1, 16'h0005);
        cycle(0, 0, '0);
        cycle(0, 0, '0);
        cycle(0, 1, 16'h0006);
        #1;
        check("t5_dout", b1.dout, 16'h0006);
        check("t5_drop", b1.drop_cnt, base + 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] d;
            d = (($urandom % 3) == 0) ? 16'($urandom % 4) : 16'($urandom);
            cycle(($urandom % 100) == 0, ($urandom % 4) != 0, d);
        end

        // Saturation then reset mid-hold with a pending word
        cycle(1, 0, '0);
        for (int i = 0; i < 400; i++) cycle(0, 1, 16'(i + 1));
        #1;
        check("sat_drop", b1.drop_cnt, 8'hFF);
        cycle(1, 1, 16'h7777);
        #1;
        check("t6_dout", b1.dout, RV1);
        check("t6_busy", b1.busy, 0);
        check("t6_drop", b1.drop_cnt, 0);

        repeat (4) cycle(0, 0, '0);
        #2;
        check("nc_queue_drained", q0.size(), 0);
        check("c_queue_drained",  q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
